// File: rtl/mips_pkg.sv
// Shared encodings and default vectors for the MIPS fetch sequencer.
// Optional build macro: MIPS_DELAY_SLOT_EN.
package mips_pkg;

  typedef enum logic [1:0] {
    RD_BRANCH = 2'b00,
    RD_JUMP   = 2'b01,
    RD_JR     = 2'b10,
    RD_RSVD   = 2'b11
  } rd_type_e;

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_FETCH  = 2'b01,
    ST_EXC    = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch handshake between the PC sequencer
// and instruction memory.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );
endinterface

// File: rtl/next_pc_calc.sv
// Combinational redirect target for branch, jump and jr,
// plus jr misalignment detection.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  redirect_type,
  input  logic [31:0] br_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] seq;

  assign seq = pc + 32'd4;

  always_comb begin
    target     = seq;
    misaligned = 1'b0;
    unique case (1'b1)
      (redirect_type == RD_BRANCH):
        target = seq + {br_offset[29:0], 2'b00};
      (redirect_type == RD_JUMP):
        target = {seq[31:28], jump_index, 2'b00};
      (redirect_type == RD_JR): begin
        target     = jr_target;
        misaligned = |jr_target[1:0];
      end
      default: target = seq;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch sequencer for the MIPS core.
// Optional build macro: MIPS_DELAY_SLOT_EN (branch delay slot).
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic               clk,
  input  logic               rst,
  pc_fetch_ctrl_if.master    imem,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [1:0]         redirect_type,
  input  logic [31:0]        br_offset,
  input  logic [25:0]        jump_index,
  input  logic [31:0]        jr_target,
  input  logic               exc_req,
  input  logic               halt,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        epc,
  output logic [1:0]         state
);

  state_e      st;
  logic        req;
  logic [31:0] target;
  logic        misaligned;
  logic        retire;
  logic        take_redir;
  logic [31:0] seq_pc;
  logic [31:0] exc_epc;

  next_pc_calc u_calc (
    .pc            (pc),
    .redirect_type (redirect_type),
    .br_offset     (br_offset),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .target        (target),
    .misaligned    (misaligned)
  );

  assign pc_plus4       = pc + 32'd4;
  assign state          = st;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign retire         = imem.imem_ack && !stall;

`ifdef MIPS_DELAY_SLOT_EN
  logic        pend_v;
  logic [31:0] pend;

  // Inside a delay slot the faulting PC is reported as the branch.
  assign seq_pc     = pend_v ? pend : pc_plus4;
  assign exc_epc    = pend_v ? pc - 32'd4 : pc;
  assign take_redir = redirect_valid && !pend_v &&
                      (redirect_type != RD_RSVD);
`else
  assign seq_pc     = pc_plus4;
  assign exc_epc    = pc;
  assign take_redir = redirect_valid &&
                      (redirect_type != RD_RSVD);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= ST_RESET;
      pc  <= RESET_VECTOR;
      epc <= 32'd0;
      req <= 1'b0;
`ifdef MIPS_DELAY_SLOT_EN
      pend_v <= 1'b0;
      pend   <= 32'd0;
`endif
    end else begin
      unique case (st)
        ST_RESET, ST_EXC: begin
          st  <= ST_FETCH;
          req <= 1'b1;
        end
        ST_HALTED: begin
          if (exc_req) begin
            epc <= pc;
            pc  <= EXC_VECTOR;
            st  <= ST_EXC;
          end
        end
        ST_FETCH: begin
          if (retire) begin
            if (exc_req || (take_redir && misaligned)) begin
              epc <= exc_epc;
              pc  <= EXC_VECTOR;
              st  <= ST_EXC;
              req <= 1'b0;
`ifdef MIPS_DELAY_SLOT_EN
              pend_v <= 1'b0;
`endif
            end else if (halt) begin
              pc  <= seq_pc;
              st  <= ST_HALTED;
              req <= 1'b0;
`ifdef MIPS_DELAY_SLOT_EN
              pend_v <= 1'b0;
`endif
            end else if (take_redir) begin
`ifdef MIPS_DELAY_SLOT_EN
              pend   <= target;
              pend_v <= 1'b1;
              pc     <= pc_plus4;
`else
              pc <= target;
`endif
            end else begin
              pc <= seq_pc;
`ifdef MIPS_DELAY_SLOT_EN
              pend_v <= 1'b0;
`endif
            end
          end
        end
        default: st <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; honours MIPS_DELAY_SLOT_EN.
module tb_pc_fetch_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  redirect_type;
  logic [31:0] br_offset;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic [1:0]  state;
  int          tests = 0;
  int          fails = 0;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_type  (redirect_type),
    .br_offset      (br_offset),
    .jump_index     (jump_index),
    .jr_target      (jr_target),
    .exc_req        (exc_req),
    .halt           (halt),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .epc            (epc),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input logic [31:0] a);
    bus.imem_ack   = 1'b1;
    redirect_valid = 1'b1;
    redirect_type  = 2'b10;
    jr_target      = a;
    step();
    redirect_valid = 1'b0;
`ifdef MIPS_DELAY_SLOT_EN
    step();
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_type = 2'b00;
    br_offset = 32'd0;
    jump_index = 26'd0;
    jr_target = 32'd0;
    exc_req = 1'b0;
    halt = 1'b0;
    bus.imem_ack = 1'b0;
    step();
    step();
    tests++;
    if (state !== 2'b00) begin
      fails++;
      $display("FAIL rst_state got %h want 0", state);
    end
    tests++;
    if (pc !== 32'h0) begin
      fails++;
      $display("FAIL rst_pc got %h want 0", pc);
    end
    tests++;
    if (epc !== 32'h0) begin
      fails++;
      $display("FAIL rst_epc got %h want 0", epc);
    end
    rst = 1'b0;
    tests++;
    if (bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_req1 got %b want 0", bus.imem_req);
    end
    step();
    tests++;
    if (bus.imem_req !== 1'b1 || state !== 2'b01) begin
      fails++;
      $display("FAIL first_req got req=%b st=%h want 1/1",
               bus.imem_req, state);
    end
  endtask

  task automatic test_sequential;
    bus.imem_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (bus.imem_addr !== 32'(i * 4)) begin
        fails++;
        $display("FAIL seq%0d got %h want %h",
                 i, bus.imem_addr, 32'(i * 4));
      end
    end
  endtask

  task automatic test_branch;
    br_offset = 32'hFFFF_FFFE;
    redirect_type = 2'b00;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
`ifdef MIPS_DELAY_SLOT_EN
    tests++;
    if (pc !== 32'h14) begin
      fails++;
      $display("FAIL br_slot got %h want 14", pc);
    end
    step();
`endif
    tests++;
    if (pc !== 32'h0C) begin
      fails++;
      $display("FAIL branch got %h want c", pc);
    end
  endtask

  task automatic test_jump;
    goto(32'h1000_0040);
    jump_index = 26'h10;
    redirect_type = 2'b01;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
`ifdef MIPS_DELAY_SLOT_EN
    step();
`endif
    tests++;
    if (pc !== 32'h1000_0040) begin
      fails++;
      $display("FAIL jump got %h want 10000040", pc);
    end
  endtask

  task automatic test_jr_misaligned;
    goto(32'h20);
    jr_target = 32'h102;
    redirect_type = 2'b10;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    tests++;
    if (pc !== 32'h180 || epc !== 32'h20) begin
      fails++;
      $display("FAIL jr_bad got pc=%h epc=%h want 180/20",
               pc, epc);
    end
    tests++;
    if (state !== 2'b10 || bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL jr_flush got st=%h req=%b want 2/0",
               state, bus.imem_req);
    end
    step();
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h180) begin
      fails++;
      $display("FAIL jr_refetch got req=%b a=%h want 1/180",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stall;
    goto(32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.imem_addr !== 32'h8) begin
        fails++;
        $display("FAIL stall%0d got %h want 8",
                 i, bus.imem_addr);
      end
    end
    stall = 1'b0;
    step();
    tests++;
    if (bus.imem_addr !== 32'hC) begin
      fails++;
      $display("FAIL stall_rel got %h want c", bus.imem_addr);
    end
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (pc !== 32'hC || bus.imem_req !== 1'b1) begin
        fails++;
        $display("FAIL noack%0d got pc=%h req=%b want c/1",
                 i, pc, bus.imem_req);
      end
    end
    exc_req = 1'b1;
    step();
    tests++;
    if (state !== 2'b01) begin
      fails++;
      $display("FAIL exc_hold got %h want 1", state);
    end
    bus.imem_ack = 1'b1;
    step();
    exc_req = 1'b0;
    tests++;
    if (state !== 2'b10 || epc !== 32'hC) begin
      fails++;
      $display("FAIL exc_take got st=%h epc=%h want 2/c",
               state, epc);
    end
    step();
  endtask

  task automatic test_halt;
    goto(32'h30);
    halt = 1'b1;
    step();
    halt = 1'b0;
    tests++;
    if (state !== 2'b11 || pc !== 32'h34) begin
      fails++;
      $display("FAIL halt got st=%h pc=%h want 3/34",
               state, pc);
    end
    step();
    step();
    tests++;
    if (bus.imem_req !== 1'b0 || pc !== 32'h34) begin
      fails++;
      $display("FAIL halted got req=%b pc=%h want 0/34",
               bus.imem_req, pc);
    end
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    tests++;
    if (state !== 2'b10 || epc !== 32'h34 ||
        pc !== 32'h180) begin
      fails++;
      $display("FAIL halt_exc got st=%h epc=%h pc=%h",
               state, epc, pc);
    end
    step();
  endtask

  task automatic test_reserved;
    redirect_type = 2'b11;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    tests++;
    if (pc !== 32'h184) begin
      fails++;
      $display("FAIL rsvd got %h want 184", pc);
    end
  endtask

  task automatic test_wrap;
    goto(32'hFFFF_FFFC);
    tests++;
    if (pc_plus4 !== 32'h0) begin
      fails++;
      $display("FAIL wrap_p4 got %h want 0", pc_plus4);
    end
    step();
    tests++;
    if (pc !== 32'h0) begin
      fails++;
      $display("FAIL wrap got %h want 0", pc);
    end
  endtask

`ifdef MIPS_DELAY_SLOT_EN
  task automatic test_delay_slot;
    goto(32'h40);
    jump_index = 26'h80;
    redirect_type = 2'b01;
    redirect_valid = 1'b1;
    step();
    tests++;
    if (pc !== 32'h44) begin
      fails++;
      $display("FAIL ds_slot got %h want 44", pc);
    end
    redirect_type = 2'b00;
    br_offset = 32'h10;
    step();
    redirect_valid = 1'b0;
    tests++;
    if (pc !== 32'h200) begin
      fails++;
      $display("FAIL ds_target got %h want 200", pc);
    end
    jump_index = 26'h100;
    redirect_type = 2'b01;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    tests++;
    if (epc !== 32'h200 || pc !== 32'h180) begin
      fails++;
      $display("FAIL ds_exc got epc=%h pc=%h want 200/180",
               epc, pc);
    end
    step();
  endtask
`endif

  task automatic test_rst_mid;
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (state !== 2'b00 || pc !== 32'h0 ||
        bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid got st=%h pc=%h req=%b",
               state, pc, bus.imem_req);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_jr_misaligned();
    test_stall();
    test_halt();
    test_reserved();
    test_wrap();
`ifdef MIPS_DELAY_SLOT_EN
    test_delay_slot();
`endif
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequencer for the program counter register in the MIPS core.
- Owns the PC and issues fetch requests to instruction memory over a req/ack handshake.
- Selects the next PC: sequential, branch, jump, jr, exception vector or halt.
- Applies stalls, and sits between the control unit/ALU compare outputs and the instruction memory.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0180, PC value loaded on exception or misaligned jr

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address, always equal to pc
imem_ack  in  1  instruction returned this cycle; current instruction executes this cycle
stall  in  1  hazard hold; blocks retire of the acked instruction
redirect_valid  in  1  current instruction changes control flow
redirect_type  in  2  00 branch, 01 jump, 10 jr, 11 reserved (treated as sequential)
br_offset  in  32  sign-extended word offset for branch
jump_index  in  26  j/jal target index
jr_target  in  32  register target for jr
exc_req  in  1  exception/interrupt request
halt  in  1  halt instruction retiring
pc  out  32  current PC
pc_plus4  out  32  pc + 4, modulo 2^32
epc  out  32  PC of the instruction that took the exception
state  out  2  00 RESET, 01 FETCH, 10 EXC, 11 HALTED

Behaviour:
- Reset (rst high at an edge): state=RESET, pc=RESET_VECTOR, epc=0, imem_req=0. Pending delay-slot state is cleared.
- rst overrides everything, including mid-handshake; an outstanding request is dropped with no retire.
- RESET: imem_req=0. Next edge goes to FETCH.
- FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ack.
- Retire = FETCH && imem_ack && !stall.
- On a stall cycle (imem_ack && stall) pc holds and the same address is re-fetched next cycle.
- Retire priority: exc_req > halt > redirect_valid > sequential.
  - exc_req: epc<=pc, pc<=EXC_VECTOR, state<=EXC.
  - halt: pc<=pc_plus4, state<=HALTED.
  - branch: pc<=pc_plus4+(br_offset<<2), truncated to 32 bits.
  - jump: pc<={pc_plus4[31:28], jump_index, 2'b00}.
  - jr with jr_target[1:0]==0: pc<=jr_target.
  - jr with jr_target[1:0]!=0: handled as an exception (epc<=pc, pc<=EXC_VECTOR, state<=EXC).
  - sequential (no redirect, or type 11): pc<=pc_plus4.
- exc_req without imem_ack in FETCH is held off until retire; the requester keeps it asserted.
- EXC: imem_req=0 for exactly one cycle (flush). Next edge goes to FETCH.
- HALTED: imem_req=0 and pc frozen. exc_req in HALTED sets epc<=pc, pc<=EXC_VECTOR, state<=EXC. Otherwise only rst exits HALTED.
- Latency: one fetch per cycle when imem_ack is returned in the request cycle. First request is asserted the 2nd cycle after rst deasserts.
- Wrap: pc 32'hFFFF_FFFC sequential gives 32'h0000_0000. Branch arithmetic wraps silently.

Optional Feature:
MIPS_DELAY_SLOT_EN
- Defined: a retiring redirect stores its target in a pending register and pc advances sequentially. The next retire (the delay slot) loads the pending target instead of pc_plus4.
- Defined: a redirect retiring in the delay slot is ignored. An exception in the delay slot clears pending and sets epc to the branch PC (delay-slot pc - 4).
- Undefined: redirect takes effect immediately and no pending register exists.

Decomposition:
- Package mips_pkg holds: redirect_type encodings (RD_BRANCH, RD_JUMP, RD_JR), state encodings, and default RESET_VECTOR/EXC_VECTOR constants.
- Sub-module next_pc_calc: combinational; takes pc, br_offset, jump_index, jr_target and redirect_type, and returns target plus a misaligned flag. The FSM and registers stay in pc_fetch_ctrl.

Test Plan:
- rst 2 cycles, then imem_ack tied high: pc sequence 0x0, 0x4, 0x8, 0xC, with imem_req first high 2 cycles after rst falls.
- At pc=0x10, branch with br_offset=-2: next pc=0x0C. Jump at pc=0x1000_0040 with jump_index=0x10 gives 0x1000_0040.
- At pc=0x20, jr_target=0x102: pc=0x180, epc=0x20, one cycle with imem_req=0, then a fetch at 0x180.
- At pc=0x8, stall high 3 cycles with ack high: imem_addr stays 0x8 for 4 cycles, then moves to 0xC. imem_ack held low 5 cycles: no pc change.
- halt at pc=0x30 goes to HALTED with pc=0x34 and no requests. exc_req then gives epc=0x34, pc=0x180. rst mid-FETCH gives pc=0x0, state RESET.
- With MIPS_DELAY_SLOT_EN, at pc=0x40, jump to 0x200: pc sequence is 0x44 then 0x200.
